// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register with a skid slot, a synchronous flush and
// a saturating counter of output-stall cycles. out_valid comes straight from a flop.
module pipe_skid_reg #(
  parameter int                DATA_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer, out_xfer;

  // in_ready looks only at our own state and flush, never at out_ready.
  assign in_ready  = (state_q != FULL) && !flush;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (out_xfer && in_xfer) begin
          main_d = in_data;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // flush overrides every transition above
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end
    out_valid_d = (state_d != EMPTY);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (out_valid_q && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: the reference is an ordered queue of accepted
// payloads (capacity 2) plus a saturating stall counter and the last-delivered value.
module tb_pipe_skid_reg;

  localparam int DATA_W = 3;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_skid_reg #(.DATA_W(DATA_W), .RESET_VAL('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_last = '0;
  int                m_cnt  = 0;
  bit                mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, then advance the model over the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      bit m_valid;
      m_valid = (q.size() > 0);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) && !flush});
      chk("stall_cnt", {24'd0, stall_cnt}, m_cnt);
      if (m_valid) chk("out_data", {29'd0, out_data}, {29'd0, q[0]});
      else         chk("out_data_hold", {29'd0, out_data}, {29'd0, m_last});
      if (m_valid && out_ready) m_last = q.pop_front();
      if (flush) begin
        q.delete();
        m_last = '0;
        m_cnt  = 0;
      end else if (m_valid && !out_ready) begin
        m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
    end
  end

  // Stimulus: drive at posedge+1, record acceptance just after the monitor has run.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    #2;
    if (in_valid && in_ready) q.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", {29'd0, out_data}, 32'd0);
    chk("rst_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    #6 reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // streaming
    step(1, 3'd1, 1, 0);
    step(1, 3'd2, 1, 0);
    step(1, 3'd3, 1, 0);
    step(0, 3'd0, 1, 0);

    // backpressure: 5 and 6 fill both slots, 7 waits its turn
    step(1, 3'd5, 0, 0);
    step(1, 3'd6, 0, 0);
    step(1, 3'd7, 0, 0);
    step(1, 3'd7, 1, 0);
    step(1, 3'd7, 1, 0);
    step(0, 3'd0, 1, 0);
    step(0, 3'd0, 1, 0);

    // flush while FULL with an offer pending
    step(1, 3'd4, 0, 0);
    step(1, 3'd5, 0, 0);
    step(1, 3'd6, 0, 1);
    step(0, 3'd0, 0, 0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_out_data", {29'd0, out_data}, 32'd0);

    // stall counter saturation
    step(1, 3'd2, 0, 0);
    repeat (300) step(0, 3'd0, 0, 0);
    chk("stall_sat", {24'd0, stall_cnt}, CNT_MAX);
    step(0, 3'd0, 1, 0);
    step(0, 3'd0, 1, 0);
    chk("stall_hold", {24'd0, stall_cnt}, CNT_MAX);
    step(0, 3'd0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    end
    repeat (3) step(0, 3'd0, 1, 0);

    // async reset while BUSY, between clock edges
    step(1, 3'd6, 0, 0);
    in_valid = 1'b0;
    mon_en   = 1'b0;
    chk("pre_rst_busy", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_data", {29'd0, out_data}, 32'd0);
    chk("arst_stall_cnt", {24'd0, stall_cnt}, 32'd0);
    q.delete();
    m_last = '0;
    m_cnt  = 0;
    reset  = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    step(1, 3'd3, 1, 0);
    step(0, 3'd0, 1, 0);
    step(0, 3'd0, 0, 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 3, SHALL set the payload width in bits (default covers RegWrite plus the 2-bit ResultSrc).
REQ-002 Parameter RESET_VAL, default 0 (DATA_W bits), SHALL be the payload value loaded on reset and on flush.
REQ-003 Parameter CNT_W, default 8, SHALL set the stall-counter width in bits.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL mean the upstream stage offers in_data this cycle.
REQ-007 in_ready  output  1  SHALL mean this block accepts in_data this cycle.
REQ-008 in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-009 out_valid  output  1  SHALL mean out_data holds a valid payload.
REQ-010 out_ready  input  1  SHALL mean the downstream stage accepts out_data this cycle.
REQ-011 out_data  output  DATA_W  SHALL carry the downstream payload.
REQ-012 flush  input  1  SHALL be a synchronous request to discard all held payloads.
REQ-013 stall_cnt  output  CNT_W  SHALL count the cycles in which the output stalled.

Function
REQ-014 A transfer SHALL occur on an edge where valid and ready on the same side are both 1; the input side is in_valid with in_ready, the output side is out_valid with out_ready.
REQ-015 The block SHALL hold a main register (drives out_data) and a skid register, and SHALL track state EMPTY, BUSY (main only) or FULL (main plus skid).
REQ-016 out_valid SHALL be 1 exactly when the state is BUSY or FULL, and SHALL be driven from a register with no combinational path from any input.
REQ-017 in_ready SHALL be 1 exactly when the state is not FULL and flush is 0; in_ready SHALL NOT depend on out_ready.
REQ-018 From EMPTY: on an input transfer, main SHALL load in_data and the state SHALL go to BUSY; otherwise the state SHALL stay EMPTY.
REQ-019 From BUSY: the next state SHALL depend on the output transfer (out_ready) and the input transfer as follows.
- Output and input transfer: main SHALL load in_data and the state SHALL stay BUSY.
- Output transfer only: the state SHALL go to EMPTY.
- Input transfer only: skid SHALL load in_data and the state SHALL go to FULL.
- Neither: the state SHALL be held.
REQ-020 From FULL: on an output transfer, main SHALL load skid and the state SHALL go to BUSY; otherwise the state SHALL be held.
REQ-021 Latency SHALL be one cycle: data accepted at edge N SHALL appear on out_data after edge N when main is loaded.
REQ-022 Payloads SHALL leave in acceptance order, with no loss or duplication.
REQ-023 flush SHALL have priority over every other event: the next state SHALL be EMPTY, main and skid SHALL load RESET_VAL, and stall_cnt SHALL clear to 0.
REQ-024 The input offer SHALL be ignored during a flush cycle; out_valid is not masked in that cycle, and an output transfer in that cycle SHALL count as completed.
REQ-025 After a payload drains to EMPTY, out_data SHALL hold the last payload.
REQ-026 stall_cnt SHALL increment by 1 on each edge where out_valid is 1 and out_ready is 0.
REQ-027 stall_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 stall_cnt SHALL change only through REQ-026, REQ-027 and flush.

Reset
REQ-029 While reset is 0, asynchronously and without waiting for a clock edge:
- the state SHALL be EMPTY;
- out_valid SHALL be 0 and in_ready SHALL be 1;
- main, skid and out_data SHALL be RESET_VAL;
- stall_cnt SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard all held payloads.
REQ-031 The first transfer SHALL be possible on the first rising edge after reset returns to 1.

Verification
REQ-032 The bench SHALL cover these directed scenarios (DATA_W=3, CNT_W=8):
- Reset -> out_valid=0, in_ready=1, out_data=0, stall_cnt=0.
- Streaming: out_ready=1, in_data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later, in_ready constantly 1.
- Backpressure: load 5, out_ready=0, offer 6 -> FULL, in_ready=0, 7 offered and not accepted; raise out_ready -> outputs 5 then 6, 7 is accepted afterwards, order intact.
- Flush while FULL: flush=1 with in_valid=1 -> next cycle EMPTY, out_valid=0, out_data=0, stall_cnt=0, offered payload dropped.
- Stall counter: hold out_valid=1, out_ready=0 for 300 cycles -> stall_cnt=255, stays 255.
- Asynchronous reset asserted between clock edges while BUSY -> out_valid falls to 0 immediately, before the next edge.
